// File: rtl/ax_level_governor.sv
// Per-channel approximation-level governor: manual/adaptive/exact targets,
// window-based quality evaluation, and a request/acknowledge level handshake.
module ax_level_governor #(
    parameter int NUM_CH  = 4,
    parameter int LEVEL_W = 3,
    parameter int CNT_W   = 16,
    parameter int WINDOW  = 1024,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfgWe,
    input  logic [CH_W-1:0]           cfgCh,
    input  logic [1:0]                cfgMode,
    input  logic [LEVEL_W-1:0]        cfgLevel,
    input  logic [CNT_W-1:0]          cfgThreshold,
    input  logic [NUM_CH-1:0]         evt,
    input  logic                      forceExact,
    output logic [NUM_CH-1:0]         chgReq,
    input  logic [NUM_CH-1:0]         chgAck,
    output logic [NUM_CH*LEVEL_W-1:0] pendLevel,
    output logic [NUM_CH*LEVEL_W-1:0] axLevel,
    output logic                      windowDone
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [1:0] MODE_ADAPTIVE = 2'd1;
    localparam logic [1:0] MODE_EXACT    = 2'd2;
    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    typedef enum logic {IDLE, PEND} state_t;

    logic [WIN_W-1:0] winCnt;

    assign windowDone = (winCnt == WIN_W'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winCnt <= '0;
        end else begin
            winCnt <= windowDone ? '0 : winCnt + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        logic [CNT_W-1:0]   evtCnt, evalCnt, thresh;
        logic [1:0]         mode, modeNxt;
        logic [LEVEL_W-1:0] manLevel, manNxt, adTgt, adNxt, axLvl, pendLvl, target;
        logic               wrHit;
        state_t             state, stateNxt;

        assign wrHit   = cfgWe && (cfgCh == CH_W'(c));
        assign evalCnt = (evt[c] && (evtCnt != CNT_MAX)) ? evtCnt + 1'b1 : evtCnt;

        // Target is derived from the post-edge configuration so a write or an
        // adaptive step can raise chgReq on the very next cycle.
        always_comb begin
            modeNxt  = mode;
            manNxt   = manLevel;
            adNxt    = adTgt;
            target   = '0;
            stateNxt = state;
            if (wrHit) begin
                modeNxt = cfgMode;
                manNxt  = cfgLevel;
                adNxt   = axLvl;
            end else if (forceExact) begin
                adNxt = axLvl;
            end else if (windowDone && mode == MODE_ADAPTIVE) begin
                if (evalCnt > thresh) begin
                    adNxt = (axLvl == '0) ? axLvl : axLvl - 1'b1;
                end else if (evalCnt == '0) begin
                    adNxt = (axLvl == LVL_MAX) ? axLvl : axLvl + 1'b1;
                end
            end
            if (!forceExact) begin
                case (modeNxt)
                    MODE_ADAPTIVE: target = adNxt;
                    MODE_EXACT:    target = '0;
                    default:       target = manNxt;
                endcase
            end
            case (state)
                IDLE:    if (target != axLvl) stateNxt = PEND;
                PEND:    if (chgAck[c]) stateNxt = IDLE;
                default: stateNxt = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
            end else begin
                state <= stateNxt;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode     <= '0;
                manLevel <= '0;
                thresh   <= CNT_MAX;
                adTgt    <= '0;
                evtCnt   <= '0;
                axLvl    <= '0;
                pendLvl  <= '0;
            end else begin
                mode     <= modeNxt;
                manLevel <= manNxt;
                adTgt    <= adNxt;
                evtCnt   <= windowDone ? '0 : evalCnt;
                if (wrHit) thresh <= cfgThreshold;
                if (state == IDLE && stateNxt == PEND) pendLvl <= target;
                if (state == PEND && chgAck[c]) axLvl <= pendLvl;
            end
        end

        assign chgReq[c] = (state == PEND);
        assign pendLevel[c*LEVEL_W +: LEVEL_W] = pendLvl;
        assign axLevel[c*LEVEL_W +: LEVEL_W]   = axLvl;
    end

endmodule

// File: tb/tb_ax_level_governor.sv
// Directed bench for ax_level_governor: manual, adaptive, collision, hold,
// override, saturation and reset scenarios with hand-computed expectations.
module tb_ax_level_governor;

    localparam int NUM_CH  = 4;
    localparam int LEVEL_W = 3;
    localparam int CNT_W   = 2;
    localparam int WINDOW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgWe;
    logic [1:0]  cfgCh;
    logic [1:0]  cfgMode;
    logic [2:0]  cfgLevel;
    logic [1:0]  cfgThreshold;
    logic [3:0]  evt;
    logic        forceExact;
    logic [3:0]  chgReq;
    logic [3:0]  chgAck;
    logic [11:0] pendLevel;
    logic [11:0] axLevel;
    logic        windowDone;

    int nChk = 0;
    int nBad = 0;

    ax_level_governor #(
        .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .CNT_W(CNT_W), .WINDOW(WINDOW)
    ) dut (
        .clk(clk), .rst(rst), .cfgWe(cfgWe), .cfgCh(cfgCh), .cfgMode(cfgMode),
        .cfgLevel(cfgLevel), .cfgThreshold(cfgThreshold), .evt(evt),
        .forceExact(forceExact), .chgReq(chgReq), .chgAck(chgAck),
        .pendLevel(pendLevel), .axLevel(axLevel), .windowDone(windowDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [2:0] lv(input logic [11:0] v, input int c);
        return v[c*3 +: 3];
    endfunction

    task automatic cfg(input int ch, input logic [1:0] m, input logic [2:0] l, input logic [1:0] th);
        cfgCh        = 2'(ch);
        cfgMode      = m;
        cfgLevel     = l;
        cfgThreshold = th;
        cfgWe        = 1'b1;
        tick();
        cfgWe        = 1'b0;
    endtask

    task automatic ack(input logic [3:0] m);
        chgAck = m;
        tick();
        chgAck = '0;
    endtask

    task automatic setLevel(input int ch, input logic [2:0] l);
        cfg(ch, 2'd0, l, 2'd3);
        ack(4'(1 << ch));
    endtask

    // Advance until the cycle in which windowDone is high (bounded).
    task automatic waitWinDone();
        for (int i = 0; i < 2 * WINDOW + 2; i++) begin
            tick();
            if (windowDone) return;
        end
        chk("winTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgMode = '0; cfgLevel = '0;
        cfgThreshold = '0; evt = '0; forceExact = 1'b0; chgAck = '0;

        // Reset state and first window alignment
        tick(2);
        chk("rstReq", chgReq, 4'h0);
        chk("rstAx", axLevel, 12'h0);
        chk("rstPend", pendLevel, 12'h0);
        chk("rstWin", windowDone, 1'b0);
        rst = 1'b1;
        tick(6);
        chk("win6", windowDone, 1'b0);
        tick();
        chk("win7", windowDone, 1'b1);
        tick();
        chk("winWrap", windowDone, 1'b0);

        // Manual write on ch1, ack three cycles later
        cfg(1, 2'd0, 3'd5, 2'd3);
        chk("manReq", chgReq, 4'b0010);
        chk("manPend", lv(pendLevel, 1), 3'd5);
        tick(2);
        chk("manWait", chgReq, 4'b0010);
        chk("manAxOld", axLevel, 12'h0);
        ack(4'b0010);
        chk("manAx", axLevel, 12'h028);
        chk("manReqLow", chgReq, 4'h0);
        ack(4'b0001);
        chk("idleAck", axLevel, 12'h028);
        chk("idleAckReq", chgReq, 4'h0);

        // Hold: new write during PEND must not disturb pendLevel
        cfg(0, 2'd0, 3'd5, 2'd3);
        chk("holdPend0", lv(pendLevel, 0), 3'd5);
        cfg(0, 2'd0, 3'd2, 2'd3);
        chk("holdPend1", lv(pendLevel, 0), 3'd5);
        chk("holdReq", chgReq[0], 1'b1);
        ack(4'b0001);
        chk("holdAx", lv(axLevel, 0), 3'd5);
        chk("holdIdle", chgReq[0], 1'b0);
        tick();
        chk("holdReq2", chgReq[0], 1'b1);
        chk("holdPend2", lv(pendLevel, 0), 3'd2);
        ack(4'b0001);

        // Adaptive: threshold 2, level 3
        setLevel(0, 3'd3);
        waitWinDone();
        cfg(0, 2'd1, 3'd0, 2'd2);
        chk("adNoReq", chgReq[0], 1'b0);
        evt[0] = 1'b1;
        tick(3);
        evt[0] = 1'b0;
        waitWinDone();
        tick();
        chk("adDecReq", chgReq[0], 1'b1);
        chk("adDecPend", lv(pendLevel, 0), 3'd2);
        waitWinDone();
        tick();
        chk("adHold", lv(pendLevel, 0), 3'd2);
        ack(4'b0001);
        chk("adAx2", lv(axLevel, 0), 3'd2);
        tick();
        chk("adIncPend", lv(pendLevel, 0), 3'd4);
        ack(4'b0001);
        chk("adAx4", lv(axLevel, 0), 3'd4);

        // Adaptive at maximum level: zero-event window yields no request
        cfg(0, 2'd0, 3'd7, 2'd2);
        ack(4'b0001);
        waitWinDone();
        cfg(0, 2'd1, 3'd0, 2'd2);
        waitWinDone();
        tick();
        chk("maxNoReq", chgReq[0], 1'b0);
        chk("maxAx", lv(axLevel, 0), 3'd7);

        // Counter saturation: a full window of events, threshold at max
        cfg(0, 2'd0, 3'd4, 2'd3);
        ack(4'b0001);
        waitWinDone();
        cfg(0, 2'd1, 3'd0, 2'd3);
        evt[0] = 1'b1;
        waitWinDone();
        tick();
        evt[0] = 1'b0;
        chk("satNoReq", chgReq[0], 1'b0);
        chk("satAx", lv(axLevel, 0), 3'd4);

        // Event on the windowDone cycle itself is counted
        waitWinDone();
        cfg(0, 2'd1, 3'd0, 2'd0);
        waitWinDone();
        evt[0] = 1'b1;
        tick();
        evt[0] = 1'b0;
        chk("lastEvtReq", chgReq[0], 1'b1);
        chk("lastEvtPend", lv(pendLevel, 0), 3'd3);
        ack(4'b0001);

        // Collision: write on windowDone beats the adaptive step
        evt[0] = 1'b1;
        tick(2);
        evt[0] = 1'b0;
        waitWinDone();
        evt[0] = 1'b1;
        cfg(0, 2'd0, 3'd1, 2'd0);
        evt[0] = 1'b0;
        chk("colReq", chgReq[0], 1'b1);
        chk("colPend", lv(pendLevel, 0), 3'd1);
        ack(4'b0001);
        chk("colAx", lv(axLevel, 0), 3'd1);

        // Override: forceExact on levels 4,5,6,7
        setLevel(0, 3'd4);
        setLevel(1, 3'd5);
        setLevel(2, 3'd6);
        setLevel(3, 3'd7);
        chk("ovrAxInit", axLevel, 12'hFAC);
        forceExact = 1'b1;
        tick();
        chk("ovrReq", chgReq, 4'hF);
        chk("ovrPend", pendLevel, 12'h0);
        ack(4'b0100);
        chk("ovrAx", axLevel, 12'hE2C);
        chk("ovrReq2", chgReq, 4'b1011);
        ack(4'b1011);
        chk("ovrAx0", axLevel, 12'h0);
        forceExact = 1'b0;
        tick();
        chk("ovrRelReq", chgReq, 4'hF);
        chk("ovrRelPend", pendLevel, 12'hFAC);
        ack(4'hF);
        chk("ovrRelAx", axLevel, 12'hFAC);

        // Reset asserted mid-PEND and mid-window
        cfg(0, 2'd0, 3'd2, 2'd3);
        chk("preRstReq", chgReq[0], 1'b1);
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        chk("midRstReq", chgReq, 4'h0);
        chk("midRstAx", axLevel, 12'h0);
        chk("midRstPend", pendLevel, 12'h0);
        chk("midRstWin", windowDone, 1'b0);
        tick();
        rst = 1'b1;
        tick(3);
        chk("postRstReq", chgReq, 4'h0);
        chk("postRstAx", axLevel, 12'h0);

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end

endmodule
